wb_sequencer: RTL
=================

# wb_sequencer

Writeback sequencer for the multicycle MIPS datapath. Accepts a decoded writeback class from the main control unit, sequences any multi-cycle preparation, then drives the register-file data-source mux select and the register write enable for exactly one cycle. Preparation is either a shift-register load/shift or waiting for the multiplier/divider to release HI/LO. Sits between the main control FSM and the data-source mux, shift register and register file.

## Interface
- MD_TIMEOUT, 64: maximum consecutive cycles spent waiting on muldiv_busy before aborting with error.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- wb_kind  in  4  writeback class, valid with start.
  - 0 ALU, 1 LOAD, 2 MFLO, 3 MFHI, 4 SLL, 5 SRL, 6 SRA, 7 SLLV, 8 SRLV, 9 SRAV.
  - 10 SLT, 11 LUI, 12 SEXT, 13 MOVA, 14 MOVB, 15 illegal.
- muldiv_busy  in  1  multiplier/divider running; HI/LO not yet valid.
- data_src  out  4  data-source mux select.
  - 0 ALU, 1 SLS, 2 LO, 3 HI, 4 shift reg, 5 LT, 6 sign-extend, 7 shift-left-16, 8 regA, 9 regB.
- shift_ctrl  out  3  shift-register command: 000 nop, 001 load, 010 sll, 011 srl, 100 sra.
- shift_src  out  1  shift amount source: 0 = shamt field, 1 = rs[4:0].
- reg_write  out  1  register-file write enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the write is performed.
- error  out  1  one-cycle pulse on illegal kind or timeout.

## Operation
- States: IDLE, WAIT_MD, SH_LOAD, SH_OP, WRITE, ERR.
- IDLE, start=1: register wb_kind into kind_q; set data_src from kind_q's mapping; then branch:
  - kinds 0,1,10-14: go to WRITE.
  - kinds 2,3: go to WAIT_MD if muldiv_busy=1, else WRITE.
  - kinds 4-9: go to SH_LOAD; shift_src=1 for 7-9, 0 for 4-6.
  - kind 15: go to ERR; data_src unchanged.
- WAIT_MD:
  - Counter increments each cycle that muldiv_busy=1.
  - muldiv_busy=0 → WRITE.
  - Counter reaches MD_TIMEOUT → ERR.
  - Counter clears on entry.
- SH_LOAD: shift_ctrl=001 for one cycle → SH_OP.
- SH_OP: shift_ctrl=sll/srl/sra for one cycle → WRITE.
  - sll for 4/7, srl for 5/8, sra for 6/9.
- WRITE: reg_write=1, done=1 → IDLE.
- ERR: error=1, reg_write=0 → IDLE.
- data_src is registered and held until the next accepted start, so the mux output is stable through WRITE and after.
- shift_src holds until the next accepted start.
- shift_ctrl is 000 in every state other than SH_LOAD/SH_OP.
- All outputs are functions of state and registered values only; no combinational input→output path.
- start while busy=1 is ignored; no queuing.
- Reset values: state IDLE, data_src 0, shift_ctrl 000, shift_src 0, reg_write 0, busy 0, done 0, error 0, counter 0.
- Reset in any state, including mid-shift or WAIT_MD, returns to IDLE at the next edge with no write.

## Timing
- start sampled high at edge 0 gives the following write cycle:
  - simple kinds: reg_write/done high in cycle 1.
  - shifts: SH_LOAD in cycle 1, SH_OP in cycle 2, WRITE in cycle 3.
  - MFHI/MFLO, not busy: WRITE in cycle 1.
  - MFHI/MFLO, busy: WRITE in the cycle after the first cycle muldiv_busy is sampled low.
- Timeout: muldiv_busy held high → error in cycle MD_TIMEOUT+1 after start.
- Back-to-back: a new start is accepted in the first IDLE cycle after WRITE/ERR; minimum spacing is 2 cycles.
- busy rises in cycle 1 and falls in the cycle after WRITE/ERR.

## Structure
- Package wb_pkg holds:
  - wb_kind codes, data_src codes, shift_ctrl codes.
  - the state enum.
  - the MD_TIMEOUT counter width ($clog2(MD_TIMEOUT+1)).
- Sub-module wb_kind_decode (combinational): maps wb_kind to {data_src, class simple/muldiv/shift/illegal, shift op, shift_src}.
- The FSM, counter and output registers live in wb_sequencer.

## Test plan
- Reset then idle: all outputs 0; start with kind 0 → cycle 1: data_src=0, reg_write=1, done=1; cycle 2: busy=0.
- Kind 8 (SRLV) → shift_src=1; cycle 1 shift_ctrl=001, cycle 2 =011, cycle 3 reg_write=1 with data_src=4.
- Kind 3 (MFHI), muldiv_busy high 5 cycles after start → WAIT_MD 5 cycles, then reg_write=1 with data_src=3.
- MD_TIMEOUT=8, kind 2 with muldiv_busy stuck high → error pulse at cycle 9, reg_write never asserted, busy drops after.
- Kind 15 → error=1 in cycle 1, data_src unchanged. Start pulses during a shift sequence are ignored.
- Assert reset in SH_OP of kind 6 → next cycle all outputs at reset values, no reg_write. Kind 11 afterward → data_src=7 write in cycle 1.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared codes for the writeback sequencer: kind and mux encodings, shift commands,
// FSM state type and the MD wait-counter width helper.
package wb_pkg;

  typedef enum logic [3:0] {
    K_ALU  = 4'd0,  K_LOAD = 4'd1,  K_MFLO = 4'd2,  K_MFHI = 4'd3,
    K_SLL  = 4'd4,  K_SRL  = 4'd5,  K_SRA  = 4'd6,  K_SLLV = 4'd7,
    K_SRLV = 4'd8,  K_SRAV = 4'd9,  K_SLT  = 4'd10, K_LUI  = 4'd11,
    K_SEXT = 4'd12, K_MOVA = 4'd13, K_MOVB = 4'd14, K_ILLEGAL = 4'd15
  } wb_kind_e;

  typedef enum logic [3:0] {
    SRC_ALU   = 4'd0, SRC_SLS  = 4'd1, SRC_LO   = 4'd2, SRC_HI   = 4'd3,
    SRC_SHREG = 4'd4, SRC_LT   = 4'd5, SRC_SEXT = 4'd6, SRC_LUI  = 4'd7,
    SRC_REGA  = 4'd8, SRC_REGB = 4'd9
  } data_src_e;

  typedef enum logic [2:0] {
    SH_NOP = 3'b000, SH_LD = 3'b001, SH_SLL = 3'b010, SH_SRL = 3'b011, SH_SRA = 3'b100
  } shift_ctrl_e;

  typedef enum logic [1:0] {
    CLS_SIMPLE, CLS_MULDIV, CLS_SHIFT, CLS_ILLEGAL
  } wb_class_e;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_MD, S_SH_LOAD, S_SH_OP, S_WRITE, S_ERR
  } state_e;

  typedef struct packed {
    data_src_e   data_src;
    wb_class_e   cls;
    shift_ctrl_e shift_op;
    logic        shift_src;
  } decode_t;

  localparam int unsigned MD_TIMEOUT_DEFAULT = 64;

  function automatic int unsigned md_cnt_w(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wb_sequencer_if.sv
// Control-side bundle of the writeback sequencer: request/status from the main
// control FSM and the mux/shift/regfile controls it produces.
interface wb_sequencer_if;
  logic       start;
  logic [3:0] wb_kind;
  logic       muldiv_busy;
  logic [3:0] data_src;
  logic [2:0] shift_ctrl;
  logic       shift_src;
  logic       reg_write;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    output start, wb_kind, muldiv_busy,
    input  data_src, shift_ctrl, shift_src, reg_write, busy, done, error
  );

  modport slave (
    input  start, wb_kind, muldiv_busy,
    output data_src, shift_ctrl, shift_src, reg_write, busy, done, error
  );
endinterface

// File: rtl/wb_kind_decode.sv
// Combinational decode of a writeback class into mux select, sequencing class,
// shift operation and shift-amount source.
module wb_kind_decode
  import wb_pkg::*;
(
  input  logic [3:0] i_wb_kind,
  output decode_t    o_dec
);

  always_comb begin
    o_dec = '{SRC_ALU, CLS_SIMPLE, SH_NOP, 1'b0};
    case (wb_kind_e'(i_wb_kind))
      K_ALU:     o_dec = '{SRC_ALU,   CLS_SIMPLE,  SH_NOP, 1'b0};
      K_LOAD:    o_dec = '{SRC_SLS,   CLS_SIMPLE,  SH_NOP, 1'b0};
      K_MFLO:    o_dec = '{SRC_LO,    CLS_MULDIV,  SH_NOP, 1'b0};
      K_MFHI:    o_dec = '{SRC_HI,    CLS_MULDIV,  SH_NOP, 1'b0};
      K_SLL:     o_dec = '{SRC_SHREG, CLS_SHIFT,   SH_SLL, 1'b0};
      K_SRL:     o_dec = '{SRC_SHREG, CLS_SHIFT,   SH_SRL, 1'b0};
      K_SRA:     o_dec = '{SRC_SHREG, CLS_SHIFT,   SH_SRA, 1'b0};
      K_SLLV:    o_dec = '{SRC_SHREG, CLS_SHIFT,   SH_SLL, 1'b1};
      K_SRLV:    o_dec = '{SRC_SHREG, CLS_SHIFT,   SH_SRL, 1'b1};
      K_SRAV:    o_dec = '{SRC_SHREG, CLS_SHIFT,   SH_SRA, 1'b1};
      K_SLT:     o_dec = '{SRC_LT,    CLS_SIMPLE,  SH_NOP, 1'b0};
      K_LUI:     o_dec = '{SRC_LUI,   CLS_SIMPLE,  SH_NOP, 1'b0};
      K_SEXT:    o_dec = '{SRC_SEXT,  CLS_SIMPLE,  SH_NOP, 1'b0};
      K_MOVA:    o_dec = '{SRC_REGA,  CLS_SIMPLE,  SH_NOP, 1'b0};
      K_MOVB:    o_dec = '{SRC_REGB,  CLS_SIMPLE,  SH_NOP, 1'b0};
      K_ILLEGAL: o_dec = '{SRC_ALU,   CLS_ILLEGAL, SH_NOP, 1'b0};
      default:   o_dec = '{SRC_ALU,   CLS_ILLEGAL, SH_NOP, 1'b0};
    endcase
  end

endmodule

// File: rtl/wb_sequencer.sv
// Writeback sequencer: accepts a decoded writeback class, runs shift or HI/LO
// wait preparation, then pulses the register write for one cycle.
module wb_sequencer
  import wb_pkg::*;
#(
  parameter int unsigned MD_TIMEOUT = MD_TIMEOUT_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  wb_sequencer_if.slave  bus
);

  localparam int unsigned CNT_W = md_cnt_w(MD_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  decode_t     w_dec;
  state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  data_src_e   r_data_src;
  shift_ctrl_e r_shift_op;
  shift_ctrl_e r_shift_ctrl;
  logic        r_shift_src;
  logic        r_reg_write;
  logic        r_busy;
  logic        r_done;
  logic        r_error;

  wb_kind_decode u_decode (
    .i_wb_kind (bus.wb_kind),
    .o_dec     (w_dec)
  );

  // Outputs are loaded on the transition into a state so they are valid for that whole state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_data_src   <= SRC_ALU;
      r_shift_op   <= SH_NOP;
      r_shift_ctrl <= SH_NOP;
      r_shift_src  <= 1'b0;
      r_reg_write  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_shift_ctrl <= SH_NOP;
      r_reg_write  <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_busy       <= 1'b1;
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          if (bus.start) begin
            r_busy      <= 1'b1;
            r_cnt       <= '0;
            r_shift_op  <= w_dec.shift_op;
            r_shift_src <= w_dec.shift_src;
            if (w_dec.cls != CLS_ILLEGAL) r_data_src <= w_dec.data_src;
            case (w_dec.cls)
              CLS_SIMPLE: begin
                r_state     <= S_WRITE;
                r_reg_write <= 1'b1;
                r_done      <= 1'b1;
              end
              CLS_MULDIV: begin
                if (bus.muldiv_busy) begin
                  r_state <= S_WAIT_MD;
                end else begin
                  r_state     <= S_WRITE;
                  r_reg_write <= 1'b1;
                  r_done      <= 1'b1;
                end
              end
              CLS_SHIFT: begin
                r_state      <= S_SH_LOAD;
                r_shift_ctrl <= SH_LD;
              end
              default: begin
                r_state <= S_ERR;
                r_error <= 1'b1;
              end
            endcase
          end
        end
        S_WAIT_MD: begin
          if (!bus.muldiv_busy) begin
            r_state     <= S_WRITE;
            r_reg_write <= 1'b1;
            r_done      <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
            if (r_cnt == CNT_LAST) begin
              r_state <= S_ERR;
              r_error <= 1'b1;
            end
          end
        end
        S_SH_LOAD: begin
          r_state      <= S_SH_OP;
          r_shift_ctrl <= r_shift_op;
        end
        S_SH_OP: begin
          r_state     <= S_WRITE;
          r_reg_write <= 1'b1;
          r_done      <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_src   = r_data_src;
  assign bus.shift_ctrl = r_shift_ctrl;
  assign bus.shift_src  = r_shift_src;
  assign bus.reg_write  = r_reg_write;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.error      = r_error;

endmodule
